// File: rtl/chan_pkg.sv
// Shared constants for the channel framer: header layout and framer FSM encoding.
package chan_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int unsigned SEQ_LSB  = 0;
    localparam int unsigned CHAN_LSB = 16;
    localparam int unsigned SYNC_LSB = 24;

    typedef enum logic {
        StHeader  = 1'b0,
        StPayload = 1'b1
    } state_e;

endpackage

// File: rtl/axi_skid_2.sv
// Two-entry register skid buffer; in_ready_o is registered so the upstream ready
// never depends combinationally on out_ready_i.
module axi_skid_2 #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             sync_reset_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic             rdy_q;
    logic             push, pop;

    assign push        = in_valid_i && rdy_q;
    assign pop         = (count_q != 2'd0) && out_ready_i;
    assign in_ready_o  = rdy_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = ent0_q;

    // Entry 0 is always the head; it only changes on a pop or a push into an empty buffer.
    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    ent0_d = in_data_i;
                end else begin
                    ent1_d = in_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent0_d = in_data_i;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = in_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (sync_reset_i) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            rdy_q   <= (count_d != 2'd2);
        end
    end

endmodule

// File: rtl/axi_chan_framer.sv
// Prepends a {sync, chan_id, seq} header to each AXI-stream frame and forces tlast
// once a frame reaches MAX_FRAME payload words.
module axi_chan_framer
    import chan_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_FRAME  = 256,
    parameter int unsigned CNT_WIDTH  = 9,
    parameter logic [7:0]  SYNC_BYTE  = chan_pkg::SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic [7:0]            chan_id,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  trunc_pulse,
    output logic [15:0]           seq_num
);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [15:0]           seq_q, seq_d;
    logic                  trunc_q, trunc_d;
    logic                  skid_rdy, skid_vld;
    logic                  push_vld, s_ready, out_last, force_last;
    logic [DATA_WIDTH:0]   push_data, skid_out;
    logic [DATA_WIDTH-1:0] hdr;

    assign force_last = (cnt_q == CNT_WIDTH'(MAX_FRAME - 1));

    always_comb begin
        hdr                  = '0;
        hdr[SYNC_LSB +: 8]   = SYNC_BYTE;
        hdr[CHAN_LSB +: 8]   = chan_id;
        hdr[SEQ_LSB  +: 16]  = seq_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        trunc_d   = 1'b0;
        s_ready   = 1'b0;
        out_last  = 1'b0;
        push_vld  = 1'b0;
        push_data = {1'b0, hdr};
        unique case (state_q)
            // A header is only pushed once a sample is actually waiting.
            StHeader: begin
                push_vld = s_axis_tvalid;
                if (s_axis_tvalid && skid_rdy) begin
                    state_d = StPayload;
                end
            end
            StPayload: begin
                s_ready   = skid_rdy;
                push_vld  = s_axis_tvalid;
                out_last  = s_axis_tlast || force_last;
                push_data = {out_last, s_axis_tdata};
                if (s_axis_tvalid && skid_rdy) begin
                    if (out_last) begin
                        cnt_d   = '0;
                        seq_d   = seq_q + 16'd1;
                        state_d = StHeader;
                        trunc_d = force_last && !s_axis_tlast;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= StHeader;
            cnt_q   <= '0;
            seq_q   <= 16'd0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            trunc_q <= trunc_d;
        end
    end

    axi_skid_2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk_i        (clk),
        .sync_reset_i (sync_reset),
        .in_valid_i   (push_vld),
        .in_data_i    (push_data),
        .in_ready_o   (skid_rdy),
        .out_valid_o  (skid_vld),
        .out_data_o   (skid_out),
        .out_ready_i  (m_axis_tready)
    );

    assign s_axis_tready = s_ready && !sync_reset;
    assign m_axis_tvalid = skid_vld && !sync_reset;
    assign m_axis_tdata  = skid_out[DATA_WIDTH-1:0];
    assign m_axis_tlast  = skid_out[DATA_WIDTH];
    assign trunc_pulse   = trunc_q;
    assign seq_num       = seq_q;

endmodule
